bar2of5_symbol_reader: RTL

- Front-end stage directly upstream of the 2-of-5 to 7-segment decoder.
- Samples the asynchronous scanner bar signal and measures each bar's width in clock cycles. Classifies each bar as narrow (0) or wide (1) and assembles five bars into a 5-bit 2-of-5 symbol.
- Presents the symbol as the decoder's E4..E0 inputs. Drives the decoder's active-low enable (E7..E5) from a registered status.

---
 rtl/bar2of5_pkg.sv | 26 ++
 rtl/bar2of5_symbol_reader_if.sv | 34 +++
 rtl/bar2of5_symbol_reader_bar_sync_edge.sv | 37 +++
 rtl/bar2of5_symbol_reader.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/bar2of5_pkg.sv
// bar2of5_pkg: shared types and helpers for the 2-of-5 scanner front end.
// Provides the reader FSM state type, symbol geometry and a popcount helper.
package bar2of5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BAR,
    GAP,
    EMIT
  } state_t;

  localparam int SYM_W      = 5;
  localparam int WIDE_COUNT = 2;

  function automatic logic [2:0] popcount5(
    input logic [SYM_W-1:0] v
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < SYM_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bar2of5_symbol_reader_if.sv
// bar2of5_symbol_reader_if: scanner input and decoder-facing symbol bus.
// master = reader (takes bar_in, drives sym/status); slave = consumer side.
interface bar2of5_symbol_reader_if;
  import bar2of5_pkg::*;

  logic             bar_in;
  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             sym_err;
  logic             sym_ok;
  logic             dis_n;
  logic             abort;

  modport master (
    input  bar_in,
    output sym,
    output sym_valid,
    output sym_err,
    output sym_ok,
    output dis_n,
    output abort
  );

  modport slave (
    output bar_in,
    input  sym,
    input  sym_valid,
    input  sym_err,
    input  sym_ok,
    input  dis_n,
    input  abort
  );

endinterface

// File: rtl/bar2of5_symbol_reader_bar_sync_edge.sv
// bar_sync_edge: 2-flop synchronizer with registered rise/fall pulses.
// Ports: clk, rst (async high), i_d (async level), o_s, o_rise, o_fall.
module bar_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_rise;
  logic r_fall;

  // Edges are computed from the value about to enter r_s2, so each pulse
  // lines up with the first cycle of the new synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_rise <= r_s1 & ~r_s2;
      r_fall <= ~r_s1 & r_s2;
    end
  end

  assign o_s    = r_s2;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/bar2of5_symbol_reader.sv
// bar2of5_symbol_reader: measures scanner bars, builds 2-of-5 symbols.
// Ports: clk, rst (async high), bus (master: bar_in in; sym/status out).
module bar2of5_symbol_reader
  import bar2of5_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int MIN_BAR  = 2,
  parameter int WIDE_MIN = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  bar2of5_symbol_reader_if.master     bus
);

  if (!(MIN_BAR < WIDE_MIN && WIDE_MIN < TIMEOUT &&
        TIMEOUT < (1 << CNT_W))) begin : g_bad_params
    $error("bar2of5_symbol_reader: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_BAR);
  localparam logic [CNT_W-1:0] L_WIDE = CNT_W'(WIDE_MIN);
  localparam logic [CNT_W-1:0] L_TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_MAX  = '1;
  localparam logic [2:0]       L_LAST = 3'(SYM_W - 1);
  localparam logic [2:0]       L_WC   = 3'(WIDE_COUNT);

  logic w_bar_s;
  logic w_rise;
  logic w_fall;

  bar_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.bar_in),
    .o_s    (w_bar_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [SYM_W-1:0] r_shift;
  logic [SYM_W-1:0] r_sym;
  logic             r_valid;
  logic             r_err;
  logic             r_ok;
  logic             r_dis_n;
  logic             r_abort;

  // r_cnt is the shared run-length counter: bar length in BAR,
  // gap length in GAP. Both saturate at L_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_sym   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ok    <= 1'b0;
      r_dis_n <= 1'b1;
      r_abort <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= BAR;
            r_cnt   <= CNT_W'(1);
          end
        end
        BAR: begin
          if (w_fall) begin
            if (r_cnt < L_MIN) begin
              // glitch: drop it, keep any partial symbol
              r_state <= (r_idx != 3'd0) ? GAP : IDLE;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_shift <= {r_shift[SYM_W-2:0], (r_cnt >= L_WIDE)};
              r_idx   <= r_idx + 3'd1;
              if (r_idx == L_LAST) begin
                r_state <= EMIT;
              end else begin
                r_state <= GAP;
                r_cnt   <= CNT_W'(1);
              end
            end
          end else if (w_bar_s && r_cnt != L_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (w_rise) begin
            r_state <= BAR;
            r_cnt   <= CNT_W'(1);
          end else if (r_cnt >= L_TO) begin
            r_abort <= 1'b1;
            r_idx   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (!w_bar_s && r_cnt != L_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        EMIT: begin
          r_sym   <= r_shift;
          r_valid <= 1'b1;
          r_err   <= (popcount5(r_shift) != L_WC);
          r_ok    <= (popcount5(r_shift) == L_WC);
          r_dis_n <= (popcount5(r_shift) != L_WC);
          r_idx   <= '0;
          r_shift <= '0;
          // a bar starting right after the fifth one must not be lost
          if (w_rise) begin
            r_state <= BAR;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sym       = r_sym;
  assign bus.sym_valid = r_valid;
  assign bus.sym_err   = r_err;
  assign bus.sym_ok    = r_ok;
  assign bus.dis_n     = r_dis_n;
  assign bus.abort     = r_abort;

endmodule
